// File: rtl/uart_core.sv
// uart_core: UART transmitter plus independent receiver with optional even/odd parity.
// Tx starts a frame on the first baud tick after an accepted enable; Rx flags a word at mid stop bit.
// No backpressure: enable is ignored while o_busy is high, and the receiver never stalls.
module uart_core #(
   parameter int INPUT_DATA_WIDTH = 8,
   parameter int PARITY_ENABLED   = 1,
   parameter int PARITY_TYPE      = 0,
   parameter int CLOCKS_PER_BIT   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [INPUT_DATA_WIDTH-1:0] i_data,
   output logic                        o_busy,
   output logic                        serial_out,
   input  logic                        serial_in,
   output logic [INPUT_DATA_WIDTH-1:0] received_data,
   output logic                        data_is_valid,
   output logic                        rx_error
);

   localparam int W  = INPUT_DATA_WIDTH;
   localparam int NB = W + PARITY_ENABLED + 2;
   // CLOCKS_PER_BIT is assumed to be at least 2 so that a mid-bit sample point exists.
   localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
   localparam int BW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID    = CW'(CLOCKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(W - 1);
   localparam logic [NB-1:0] SHIFT_LAST = NB'(1);

   // Even parity is the plain XOR of the data bits; odd parity is its complement.
   function automatic logic calc_parity(input logic [W-1:0] d);
      calc_parity = (PARITY_TYPE == 0) ? ^d : ~^d;
   endfunction

   // ---------------------------------------------------------------- Tx
   logic [CW-1:0] baud_cnt_q;
   logic          baud_clk;
   logic [NB-1:0] tx_frame;
   logic [NB-1:0] shift_q, shift_d;
   logic          busy_q, busy_d;
   logic          tx_q, tx_d;

   // Free-running bit timer; the wrap cycle is the Tx baud tick.
   always_ff @(posedge clk) begin
      if (reset)
         baud_cnt_q <= '0;
      else if (baud_cnt_q == CNT_LAST)
         baud_cnt_q <= '0;
      else
         baud_cnt_q <= baud_cnt_q + 1'b1;
   end

   assign baud_clk = (baud_cnt_q == CNT_LAST);

   // Frame image, LSB goes out first: start 0, data, optional parity, stop 1.
   always_comb begin
      tx_frame        = '1;
      tx_frame[0]     = 1'b0;
      tx_frame[W:1]   = i_data;
      if (PARITY_ENABLED != 0)
         tx_frame[W+1] = calc_parity(i_data);
   end

   // Load on an accepted request, otherwise shift one bit per tick; busy drops as the stop bit goes out.
   always_comb begin
      shift_d = shift_q;
      busy_d  = busy_q;
      tx_d    = tx_q;
      if (enable && !busy_q) begin
         shift_d = tx_frame;
         busy_d  = 1'b1;
      end else if (baud_clk && busy_q) begin
         tx_d    = shift_q[0];
         shift_d = shift_q >> 1;
         if (shift_q == SHIFT_LAST)
            busy_d = 1'b0;
      end
   end

   // Tx state registers; the line idles high and keeps the last (stop) level while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q <= '1;
         busy_q  <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         shift_q <= shift_d;
         busy_q  <= busy_d;
         tx_q    <= tx_d;
      end
   end

   assign o_busy     = busy_q;
   assign serial_out = tx_q;

   // ---------------------------------------------------------------- Rx
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START_BIT,
      RX_DATA_BIT,
      RX_PARITY_BIT,
      RX_STOP_BIT
   } rx_state_t;

   logic [2:0]    sync_q;
   logic          serial_in_synced;
   rx_state_t     rx_state_q;
   logic [CW-1:0] rx_cnt_q;
   logic [BW-1:0] rx_bit_q;
   logic [W-1:0]  rx_data_q;
   logic          rx_vld_q;
   logic          rx_err_q;
   logic          par_err_q;
   logic          start_detected;
   logic          sampling_strobe;

   // Three-stage synchronizer for the asynchronous line; resets to the idle level.
   always_ff @(posedge clk) begin
      if (reset)
         sync_q <= '1;
      else
         sync_q <= {sync_q[1:0], serial_in};
   end

   assign serial_in_synced = sync_q[2];
   assign start_detected   = (rx_state_q == RX_IDLE) && !serial_in_synced;
   assign sampling_strobe  = (rx_state_q != RX_IDLE) && (rx_cnt_q == CNT_MID);

   // Receive FSM: data bits walk through DATA_BIT with rx_bit_q as the bit index.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_data_q  <= '0;
         rx_vld_q   <= 1'b0;
         rx_err_q   <= 1'b0;
         par_err_q  <= 1'b0;
      end else begin
         rx_vld_q <= 1'b0;
         if (rx_state_q != RX_IDLE)
            rx_cnt_q <= (rx_cnt_q == CNT_LAST) ? '0 : rx_cnt_q + 1'b1;
         case (rx_state_q)
            RX_IDLE: begin
               if (start_detected) begin
                  rx_state_q <= RX_START_BIT;
                  rx_cnt_q   <= '0;
                  rx_data_q  <= '0;
                  rx_err_q   <= 1'b0;
                  par_err_q  <= 1'b0;
               end
            end
            RX_START_BIT: begin
               if (sampling_strobe) begin
                  if (!serial_in_synced) begin
                     rx_state_q <= RX_DATA_BIT;
                     rx_bit_q   <= '0;
                  end else begin
                     rx_state_q <= RX_IDLE;
                  end
               end
            end
            RX_DATA_BIT: begin
               if (sampling_strobe) begin
                  rx_data_q <= {serial_in_synced, rx_data_q[W-1:1]};
                  if (rx_bit_q == BIT_LAST)
                     rx_state_q <= (PARITY_ENABLED != 0) ? RX_PARITY_BIT : RX_STOP_BIT;
                  else
                     rx_bit_q <= rx_bit_q + 1'b1;
               end
            end
            RX_PARITY_BIT: begin
               if (sampling_strobe) begin
                  par_err_q  <= (serial_in_synced != calc_parity(rx_data_q));
                  rx_state_q <= RX_STOP_BIT;
               end
            end
            RX_STOP_BIT: begin
               if (sampling_strobe) begin
                  if (serial_in_synced && !par_err_q)
                     rx_vld_q <= 1'b1;
                  else
                     rx_err_q <= 1'b1;
                  rx_state_q <= RX_IDLE;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   assign received_data = rx_data_q;
   assign data_is_valid = rx_vld_q;
   assign rx_error      = rx_err_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: drives uart_core in loopback and with a hand-built serial line.
// Tx frames are compared bit by bit against a frame list built from the data word.
// Received words are queued by a monitor and compared in order against sent words.
module tb_uart_core;
   localparam int W   = 8;
   localparam int PE  = 1;
   localparam int PT  = 0;
   localparam int CPB = 8;
   localparam int NB  = W + PE + 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic [W-1:0] i_data;
   logic         o_busy;
   logic         serial_out;
   logic         serial_in;
   logic [W-1:0] received_data;
   logic         data_is_valid;
   logic         rx_error;

   logic         lb_sel;
   logic         drv_line;
   int           n_chk = 0;
   int           n_fail = 0;
   int           dbl_pulse = 0;
   logic         prev_vld = 1'b0;
   logic [W-1:0] rx_q[$];
   logic [W-1:0] exp_q[$];

   assign serial_in = lb_sel ? serial_out : drv_line;

   uart_core #(
      .INPUT_DATA_WIDTH(W),
      .PARITY_ENABLED(PE),
      .PARITY_TYPE(PT),
      .CLOCKS_PER_BIT(CPB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .i_data(i_data),
      .o_busy(o_busy),
      .serial_out(serial_out),
      .serial_in(serial_in),
      .received_data(received_data),
      .data_is_valid(data_is_valid),
      .rx_error(rx_error)
   );

   always #5 clk = ~clk;

   // Collect every reported word and note any valid pulse longer than one clock.
   always @(posedge clk) begin
      #1;
      if (data_is_valid === 1'b1) rx_q.push_back(received_data);
      if (data_is_valid === 1'b1 && prev_vld === 1'b1) dbl_pulse++;
      prev_vld = data_is_valid;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Line level for each bit time, element 0 first on the wire.
   function automatic logic [NB-1:0] frame_bits(input logic [W-1:0] d);
      logic [NB-1:0] f;
      logic          par;
      par = ($countones(d) % 2) == 1;
      if (PT == 1) par = !par;
      f[0] = 1'b0;
      for (int i = 0; i < W; i++) f[1+i] = d[i];
      if (PE == 1) f[W+1] = par;
      f[NB-1] = 1'b1;
      return f;
   endfunction

   // Request one frame and follow it until the stop bit appears; optionally retry enable mid-frame.
   task automatic send_frame(input logic [W-1:0] d, input int poke_bit);
      logic [NB-1:0] f;
      int            k;
      int            nbad;
      f = frame_bits(d);
      exp_q.push_back(d);
      enable = 1'b1;
      i_data = d;
      step();
      enable = 1'b0;
      i_data = W'($urandom);
      check_eq($sformatf("busy_set_%0h", d), o_busy, 1);
      k = 0;
      while (serial_out !== 1'b0 && k < CPB + 2) begin
         step();
         k++;
      end
      check_eq($sformatf("start_seen_%0h", d), serial_out, 0);
      for (int b = 0; b < NB - 1; b++) begin
         nbad = 0;
         for (int c = 0; c < CPB; c++) begin
            if (serial_out !== f[b] || o_busy !== 1'b1) nbad++;
            if (b == poke_bit && c == 2) begin
               enable = 1'b1;
               i_data = '1;
            end
            step();
            enable = 1'b0;
         end
         check_eq($sformatf("frame_%0h_bit%0d", d, b), nbad, 0);
      end
      check_eq($sformatf("stop_level_%0h", d), serial_out, 1);
      check_eq($sformatf("busy_clear_%0h", d), o_busy, 0);
   endtask

   // Drive a frame straight onto serial_in, optionally with the parity bit inverted.
   task automatic drive_frame(input logic [W-1:0] d, input logic flip_par);
      logic [NB-1:0] f;
      f = frame_bits(d);
      if (flip_par) f[W+1] = !f[W+1];
      for (int b = 0; b < NB; b++) begin
         drv_line = f[b];
         repeat (CPB) step();
      end
      drv_line = 1'b1;
   endtask

   // Wait for the receiver to report as many words as were sent, then compare in order.
   task automatic drain_rx(input string tag);
      int k;
      k = 0;
      while (rx_q.size() < exp_q.size() && k < 6 * CPB) begin
         step();
         k++;
      end
      check_eq({tag, "_count"}, rx_q.size(), exp_q.size());
      while (exp_q.size() > 0 && rx_q.size() > 0)
         check_eq({tag, "_data"}, rx_q.pop_front(), exp_q.pop_front());
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int nbad;
      int k;
      reset    = 1'b1;
      enable   = 1'b0;
      i_data   = '0;
      lb_sel   = 1'b1;
      drv_line = 1'b1;
      repeat (4) step();
      check_eq("rst_busy", o_busy, 0);
      check_eq("rst_serial_out", serial_out, 1);
      check_eq("rst_valid", data_is_valid, 0);
      check_eq("rst_rx_error", rx_error, 0);
      check_eq("rst_received_data", received_data, 0);
      reset = 1'b0;
      step();

      // Reference word 0xA5 and the parity-one word 0x07 in loopback.
      send_frame(8'hA5, -1);
      drain_rx("loop_a5");
      check_eq("a5_rx_error", rx_error, 0);
      send_frame(8'h07, -1);
      drain_rx("loop_07");
      check_eq("07_rx_error", rx_error, 0);

      // A second request while busy must be dropped without disturbing the frame.
      send_frame(8'h3C, 3);
      nbad = 0;
      repeat (12 * CPB) begin
         if (o_busy !== 1'b0 || serial_out !== 1'b1) nbad++;
         step();
      end
      check_eq("ignored_enable_quiet", nbad, 0);
      drain_rx("ignored_enable");

      // Back-to-back: the next request lands on the first cycle after busy falls.
      send_frame(8'h81, -1);
      send_frame(8'h5A, -1);
      drain_rx("b2b");

      // Random words with random idle gaps, some of them zero.
      for (int r = 0; r < 8; r++) begin
         repeat ($urandom_range(0, 1) * $urandom_range(0, 20)) step();
         send_frame(W'($urandom), -1);
      end
      drain_rx("rand");
      check_eq("rand_rx_error", rx_error, 0);

      // Directly driven frames: bad parity first, then a clean one.
      repeat (2 * CPB) step();
      lb_sel = 1'b0;
      drive_frame(8'h5B, 1'b1);
      repeat (2 * CPB) step();
      check_eq("badpar_rx_error", rx_error, 1);
      check_eq("badpar_no_valid", rx_q.size(), 0);
      check_eq("badpar_data_held", received_data, 8'h5B);
      exp_q.push_back(8'hC3);
      drive_frame(8'hC3, 1'b0);
      drain_rx("direct_good");
      check_eq("direct_good_rx_error", rx_error, 0);
      lb_sel = 1'b1;
      repeat (2 * CPB) step();

      // Reset in the middle of a loopback frame aborts both directions.
      enable = 1'b1;
      i_data = 8'h96;
      step();
      enable = 1'b0;
      k = 0;
      while (serial_out !== 1'b0 && k < CPB + 2) begin
         step();
         k++;
      end
      repeat (5 * CPB + CPB / 2) step();
      check_eq("midframe_busy", o_busy, 1);
      reset = 1'b1;
      step();
      check_eq("midrst_serial_out", serial_out, 1);
      check_eq("midrst_busy", o_busy, 0);
      check_eq("midrst_valid", data_is_valid, 0);
      check_eq("midrst_received_data", received_data, 0);
      reset = 1'b0;
      nbad = 0;
      repeat (2 * NB * CPB) begin
         if (o_busy !== 1'b0 || serial_out !== 1'b1 || rx_error !== 1'b0) nbad++;
         step();
      end
      check_eq("post_reset_quiet", nbad, 0);
      check_eq("post_reset_no_valid", rx_q.size(), 0);
      rx_q.delete();

      send_frame(8'h69, -1);
      drain_rx("after_reset");
      check_eq("single_cycle_valid", dbl_pulse, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter INPUT_DATA_WIDTH, default 8, data bits per frame.
REQ-002 Parameter PARITY_ENABLED, default 1, 1 = parity bit present, 0 = no parity bit.
REQ-003 Parameter PARITY_TYPE, default 0, 0 = even parity, 1 = odd parity.
REQ-004 Parameter CLOCKS_PER_BIT, default 8, clk cycles per serial bit.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  one-cycle transmit request.
REQ-008 i_data  input  INPUT_DATA_WIDTH  transmit data, sampled on accepted enable.
REQ-009 o_busy  output  1  transmitter busy.
REQ-010 serial_out  output  1  Tx line, idle high.
REQ-011 serial_in  input  1  Rx line, asynchronous, idle high.
REQ-012 received_data  output  INPUT_DATA_WIDTH  last received data word.
REQ-013 data_is_valid  output  1  one-cycle pulse when a good frame completes.
REQ-014 rx_error  output  1  parity or stop-bit error on the last frame.

Function
REQ-015 Frame format, sent LSB first: start bit 0, data bits, parity bit (if enabled), stop bit 1, giving NUMBER_OF_BITS = INPUT_DATA_WIDTH + PARITY_ENABLED + 2 (11 by default).
REQ-016 Parity bit = XOR of data bits when PARITY_TYPE=0, and XNOR of data bits when PARITY_TYPE=1.
REQ-017 Tx baud tick: a free-running counter over 0..CLOCKS_PER_BIT-1 pulses baud_clk for one clk when it wraps.
REQ-018 Tx shift register is NUMBER_OF_BITS wide and is all-ones after reset.
REQ-019 enable with o_busy=0 and reset=0:
- loads the shift register with {1, parity, i_data, 0};
- sets o_busy on the next clk edge.
REQ-020 enable while o_busy=1 is ignored; the in-flight frame is unaffected.
REQ-021 On each baud tick while busy: serial_out <= shift_reg[0], and the shift register shifts right with zero fill.
REQ-022 Each bit is held on serial_out for exactly CLOCKS_PER_BIT clk.
REQ-023 Completion: on the baud tick that drives the stop bit, o_busy clears and the shift register is 0; serial_out stays 1 while idle.
REQ-024 A new enable is accepted on the cycle after o_busy clears.
REQ-025 Rx synchronizer: serial_in passes through 3 flip-flops (reset to 1) to give serial_in_synced.
REQ-026 Rx states: IDLE, START_BIT, DATA_BIT_0..DATA_BIT_(W-1), PARITY_BIT (only if PARITY_ENABLED), STOP_BIT.
REQ-027 IDLE: serial_in_synced = 0 asserts start_detected, enters START_BIT, resets the bit-timing counter and clears received_data to 0.
REQ-028 sampling_strobe pulses once per bit, CLOCKS_PER_BIT/2 clk after bit entry (mid-bit), then every CLOCKS_PER_BIT clk.
REQ-029 START_BIT strobe: synced=0 advances to DATA_BIT_0; synced=1 is a false start and returns to IDLE.
REQ-030 DATA_BIT_n strobe: received_data <= {synced, received_data[W-1:1]}, then advance to the next state.
REQ-031 PARITY_BIT strobe: compare synced against the parity computed over the received bits, record the mismatch, advance to STOP_BIT.
REQ-032 STOP_BIT strobe with synced=1 and no mismatch: data_is_valid=1 for exactly one clk, rx_error=0.
REQ-033 STOP_BIT strobe with a mismatch or synced=0: rx_error=1 and no data_is_valid.
REQ-034 After the STOP_BIT strobe Rx returns to IDLE.
REQ-035 received_data holds its value until the next start is detected.
REQ-036 rx_error holds until the next start detection.
REQ-037 Rx operates independently of Tx; loopback of serial_out to serial_in must recover i_data exactly.

Reset
REQ-038 On reset:
- o_busy=0, serial_out=1, Tx shift register all-ones, baud counter 0;
- Rx state IDLE, synchronizer FFs 1, received_data=0, data_is_valid=0, rx_error=0.
REQ-039 Reset mid-frame aborts both Tx and Rx immediately; no data_is_valid follows.

Verification
REQ-040 Loopback, i_data=0xA5, enable 1 clk:
- o_busy=1 next clk;
- serial_out sequence 0,1,0,1,0,0,1,0,1,0(parity),1, 8 clk each;
- o_busy=0 after 88 clk;
- data_is_valid pulse with received_data=0xA5, rx_error=0.
REQ-041 Loopback i_data=0x07, even parity -> parity bit 1, received_data=0x07, rx_error=0.
REQ-042 enable pulsed again while o_busy=1 with i_data=0xFF -> frame for the first word is unchanged and no second frame starts.
REQ-043 Back-to-back: enable on the first cycle after o_busy falls -> second frame starts, and both words are received in order with two data_is_valid pulses.
REQ-044 Drive serial_in directly with a frame carrying a wrong parity bit -> rx_error=1, no data_is_valid.
REQ-045 Assert reset at bit 5 of a frame -> serial_out=1, o_busy=0, Rx IDLE, no data_is_valid.
